// File: rtl/pwm_wave_seq.sv
// Table-driven duty sequencer feeding a zPWM core: plays len entries, div+1 periods each, reps passes.
// Optional macro PWM_SEQ_GAIN_EN adds a 9-bit gain input (256 = unity) applied to every duty load.
module pwm_wave_seq #(
   parameter int pDEPTH = 100,
   parameter int pAW    = 7,
   parameter int pDW    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  logic [pAW-1:0] wr_addr,
   input  logic [pDW-1:0] wr_data,
   input  logic           start,
   input  logic           stop,
   input  logic [pAW-1:0] len,
   input  logic [7:0]     div,
   input  logic [7:0]     reps,
   input  logic           end_tick,
`ifdef PWM_SEQ_GAIN_EN
   input  logic [8:0]     gain,
`endif
   output logic           pwm_en,
   output logic [pDW-1:0] cyc_duty,
   output logic [pAW-1:0] idx,
   output logic           busy,
   output logic           done
);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

   localparam logic [pAW:0] cDEPTH = (pAW+1)'(pDEPTH);

   state_e         state_q, state_d;
   logic [pAW-1:0] len_q, len_d;
   logic [7:0]     div_q, div_d;
   logic [7:0]     reps_q, reps_d;
   logic [7:0]     per_cnt_q, per_cnt_d;
   logic [7:0]     pass_cnt_q, pass_cnt_d;
   logic [pAW-1:0] idx_q, idx_d;
   logic [pDW-1:0] duty_q, duty_d;
   logic           done_q, done_d;
   logic [pDW-1:0] tbl_q [pDEPTH];

   logic           len_ok;
   logic           wrap;
   logic [pAW-1:0] idx_adv;

   function automatic logic [pDW-1:0] f_shape(input logic [pDW-1:0] raw);
`ifdef PWM_SEQ_GAIN_EN
      logic [pDW+8:0] prod;
      prod = (pDW+9)'(raw) * (pDW+9)'(gain);
      // prod>>8 fits in pDW+1 bits; any carry into the top bit means saturation
      if (prod[pDW+8]) return '1;
      return prod[pDW+7:8];
`else
      return raw;
`endif
   endfunction

   // NOTE: the duty table has no reset so its contents survive rst_n and map onto plain RAM.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && wr_en && ({1'b0, wr_addr} < cDEPTH))
         tbl_q[wr_addr] <= wr_data;
   end

   // NOTE: every sequential register uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         div_q      <= '0;
         reps_q     <= '0;
         per_cnt_q  <= '0;
         pass_cnt_q <= '0;
         idx_q      <= '0;
         duty_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         div_q      <= div_d;
         reps_q     <= reps_d;
         per_cnt_q  <= per_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         idx_q      <= idx_d;
         duty_q     <= duty_d;
         done_q     <= done_d;
      end
   end

   assign len_ok  = (len != '0) && ({1'b0, len} <= cDEPTH);
   assign wrap    = (idx_q == len_q - pAW'(1));
   assign idx_adv = wrap ? '0 : idx_q + pAW'(1);

   // NOTE: every _d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      div_d      = div_q;
      reps_d     = reps_q;
      per_cnt_d  = per_cnt_q;
      pass_cnt_d = pass_cnt_q;
      idx_d      = idx_q;
      duty_d     = duty_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && len_ok) begin
               len_d      = len;
               div_d      = div;
               reps_d     = reps;
               per_cnt_d  = '0;
               pass_cnt_d = reps;
               state_d    = PRIME;
            end
         end
         PRIME: begin
            duty_d  = f_shape(tbl_q[0]);
            idx_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (end_tick) begin
               if (per_cnt_q == div_q) begin
                  per_cnt_d = '0;
                  if (wrap && reps_q != 8'd0 && pass_cnt_q == 8'd1) begin
                     done_d     = 1'b1;
                     duty_d     = '0;
                     idx_d      = '0;
                     pass_cnt_d = '0;
                     state_d    = IDLE;
                  end else begin
                     if (wrap && reps_q != 8'd0) pass_cnt_d = pass_cnt_q - 8'd1;
                     idx_d  = idx_adv;
                     duty_d = f_shape(tbl_q[idx_adv]);
                  end
               end else begin
                  per_cnt_d = per_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides whatever the state logic decided, including a same-cycle start
      if (stop) begin
         state_d    = IDLE;
         per_cnt_d  = '0;
         pass_cnt_d = '0;
         idx_d      = '0;
         duty_d     = '0;
         done_d     = 1'b0;
      end
   end

   always_comb begin
      pwm_en = (state_q == RUN);
      busy   = (state_q != IDLE);
   end

   assign cyc_duty = duty_q;
   assign idx      = idx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_pwm_wave_seq.sv
// Scoreboard bench for pwm_wave_seq: stimulus queues the duty expected in each PWM period,
// a monitor pops one entry per end_tick seen while pwm_en is high.
module tb_pwm_wave_seq;

   localparam int pDEPTH = 100;
   localparam int pAW    = 7;
   localparam int pDW    = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_en;
   logic [pAW-1:0] wr_addr;
   logic [pDW-1:0] wr_data;
   logic           start;
   logic           stop;
   logic [pAW-1:0] len;
   logic [7:0]     div;
   logic [7:0]     reps;
   logic           end_tick;
`ifdef PWM_SEQ_GAIN_EN
   logic [8:0]     gain;
`endif
   logic           pwm_en;
   logic [pDW-1:0] cyc_duty;
   logic [pAW-1:0] idx;
   logic           busy;
   logic           done;

   int             n_checks = 0;
   int             n_fail   = 0;
   int             done_cnt;
   logic [pDW-1:0] exp_q[$];
   logic [pDW-1:0] pat [4];

   pwm_wave_seq #(.pDEPTH(pDEPTH), .pAW(pAW), .pDW(pDW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .start    (start),
      .stop     (stop),
      .len      (len),
      .div      (div),
      .reps     (reps),
      .end_tick (end_tick),
`ifdef PWM_SEQ_GAIN_EN
      .gain     (gain),
`endif
      .pwm_en   (pwm_en),
      .cyc_duty (cyc_duty),
      .idx      (idx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (done) done_cnt++;
   endtask

   task automatic wr(input int addr, input int data);
      wr_en   = 1'b1;
      wr_addr = pAW'(addr);
      wr_data = pDW'(data);
      tick();
      wr_en   = 1'b0;
   endtask

   // Returns with the DUT in RUN and the first entry already loaded
   task automatic start_seq(input int l, input int d, input int r);
      len   = pAW'(l);
      div   = 8'(d);
      reps  = 8'(r);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic run_ticks(input int n);
      end_tick = 1'b1;
      repeat (n) tick();
      end_tick = 1'b0;
   endtask

   // Monitor: one scoreboard entry per completed PWM period
   initial begin
      forever begin
         @(negedge clk);
         if (pwm_en === 1'b1 && end_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_extra actual=%0d required=none at %0t", cyc_duty, $time);
            end else begin
               check("sb_duty", cyc_duty, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; stop = 1'b0; len = '0; div = '0; reps = '0; end_tick = 1'b0;
`ifdef PWM_SEQ_GAIN_EN
      gain = 9'd256;
`endif
      done_cnt = 0;
      pat[0] = 8'd50; pat[1] = 8'd60; pat[2] = 8'd70; pat[3] = 8'd80;
      repeat (2) tick();
      check("rst_pwm_en", pwm_en, 0);
      check("rst_duty", cyc_duty, 0);
      check("rst_idx", idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick();

      // Full 100-entry ramp, one entry per end_tick, single pass
      for (int i = 0; i < 100; i++) wr(i, i);
      for (int i = 0; i < 100; i++) exp_q.push_back(pDW'(i));
      start_seq(100, 0, 1);
      check("ramp_first_pwm_en", pwm_en, 1);
      check("ramp_first_idx", idx, 0);
      check("ramp_first_busy", busy, 1);
      done_cnt = 0;
      run_ticks(100);
      check("ramp_done", done, 1);
      check("ramp_end_pwm_en", pwm_en, 0);
      check("ramp_end_duty", cyc_duty, 0);
      check("ramp_end_idx", idx, 0);
      check("ramp_end_busy", busy, 0);
      tick();
      check("ramp_done_width", done, 0);
      check("ramp_done_count", done_cnt, 1);
      check("ramp_sb_empty", exp_q.size(), 0);

      // len=4, div=2, reps=2 with gapped end_ticks
      for (int i = 0; i < 4; i++) wr(i, pat[i]);
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 4; i++)
            repeat (3) exp_q.push_back(pat[i]);
      done_cnt = 0;
      start_seq(4, 2, 2);
      check("div_first_duty", cyc_duty, 50);
      for (int k = 0; k < 24; k++) begin
         end_tick = 1'b1;
         tick();
         end_tick = 1'b0;
         tick();
      end
      check("div_done_count", done_cnt, 1);
      check("div_end_busy", busy, 0);
      check("div_end_duty", cyc_duty, 0);
      check("div_sb_empty", exp_q.size(), 0);

      // Infinite playback, write attempt while running, then stop
      for (int k = 0; k < 250; k++) exp_q.push_back(pat[k % 4]);
      done_cnt = 0;
      start_seq(4, 0, 0);
      end_tick = 1'b1;
      for (int k = 0; k < 250; k++) begin
         wr_en   = (k == 100);
         wr_addr = 7'd1;
         wr_data = 8'hEE;
         tick();
      end
      end_tick = 1'b0;
      wr_en    = 1'b0;
      check("inf_still_busy", busy, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_pwm_en", pwm_en, 0);
      check("stop_duty", cyc_duty, 0);
      check("stop_idx", idx, 0);
      check("stop_no_done", done_cnt, 0);
      check("inf_sb_empty", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(pat[i]);
      start_seq(4, 0, 1);
      run_ticks(4);
      check("replay_done", done, 1);
      tick();
      check("replay_sb_empty", exp_q.size(), 0);

      // Illegal lengths and start+stop collision
      len = 7'd0; start = 1'b1; tick(); start = 1'b0;
      check("len0_busy", busy, 0);
      len = 7'd101; start = 1'b1; tick(); start = 1'b0;
      check("len101_busy", busy, 0);
      len = 7'd4; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check("startstop_busy", busy, 0);
      tick();
      check("startstop_busy2", busy, 0);
      check("startstop_pwm_en", pwm_en, 0);

      // Reset mid-run beats a simultaneous start, table survives
      exp_q.push_back(8'd50); exp_q.push_back(8'd50);
      exp_q.push_back(8'd60); exp_q.push_back(8'd60);
      exp_q.push_back(8'd70);
      start_seq(4, 1, 0);
      run_ticks(5);
      check("prerst_idx", idx, 2);
      rst_n = 1'b0; start = 1'b1;
      tick();
      check("midrst_pwm_en", pwm_en, 0);
      check("midrst_duty", cyc_duty, 0);
      check("midrst_idx", idx, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      rst_n = 1'b1; start = 1'b0;
      tick();
      check("postrst_busy", busy, 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(pat[i]);
      start_seq(4, 0, 1);
      run_ticks(4);
      check("rst_replay_done", done, 1);
      tick();
      check("rst_sb_empty", exp_q.size(), 0);

`ifdef PWM_SEQ_GAIN_EN
      wr(0, 200);
      gain = 9'd128;
      start_seq(1, 0, 0);
      check("gain_half", cyc_duty, 100);
      stop = 1'b1; tick(); stop = 1'b0;
      gain = 9'd511;
      start_seq(1, 0, 0);
      check("gain_sat", cyc_duty, 255);
      stop = 1'b1; tick(); stop = 1'b0;
`endif

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
